// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter (and the planned receiver).
//   uart_state_e : frame state machine encoding
//   PARITY_*     : values accepted by the PARITY parameter
//   frame_len()  : clocks from accept to tx_done inclusive, for benches
package uart_pkg;

  // ST_ prefix keeps the literals clear of the PARITY module parameter.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Counters are sized for the widest legal frame (9 data bits).
  localparam int MAX_DATA_BITS = 9;
  localparam int BIT_CNT_W     = 4;

  function automatic int frame_len(input int data_bits, input int parity,
                                   input int stop_bits, input int clks_per_bit);
    return (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer shared by the UART transmitter and receiver.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   en    : count while high
//   clr   : synchronous clear to zero (wins over en)
//   tick  : high in the last clock of each bit period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == CNT_MAX);

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start, DATA_BITS data (LSB first),
// optional parity, STOP_BITS stop bits. Line idles high.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   tx_valid : producer has a word on tx_data
//   tx_data  : word to send, sampled only on handshake
//   tx_ready : block can accept a word this cycle (IDLE)
//   tx_out   : registered serial line
//   tx_busy  : frame in progress
//   tx_done  : pulse in the last clock of the final stop bit
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | line high, waiting for tx_valid
// ST_START  | driving the start bit (0)
// ST_DATA   | driving data bits, shift register moves right
// ST_PARITY | driving the parity bit latched at accept
// ST_STOP   | driving stop bit(s), tx_done in the last clock
module uart_tx_cfg import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  uart_state_e            state, state_nxt;
  logic [DATA_BITS-1:0]   shreg;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   stop_cnt;
  logic                   par_bit;
  logic                   tick;
  logic                   accept;
  logic                   last_bit;
  logic                   last_stop;

  assign accept    = tx_valid && tx_ready;
  assign last_bit  = (bit_cnt == BIT_CNT_W'(DATA_BITS - 1));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tx_busy),
    .clr  (accept),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (accept) state_nxt = ST_START;
      ST_START:  if (tick) state_nxt = ST_DATA;
      ST_DATA:   if (tick && last_bit)
                   state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_nxt = ST_STOP;
      ST_STOP:   if (tick && last_stop) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_ready = (state == ST_IDLE);
    tx_busy  = (state != ST_IDLE);
    tx_done  = (state == ST_STOP) && tick && last_stop;
  end

  // tx_out is registered and always carries the value of the bit being
  // entered, so the start bit appears on the same edge as the accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_out   <= 1'b1;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            tx_out   <= 1'b0;
            shreg    <= tx_data;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= (PARITY == PARITY_ODD) ? ~^tx_data : ^tx_data;
          end else begin
            tx_out <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) tx_out <= shreg[0];
        end
        ST_DATA: begin
          if (tick) begin
            if (last_bit) begin
              tx_out <= (PARITY != PARITY_NONE) ? par_bit : 1'b1;
            end else begin
              tx_out  <= shreg[1];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
        ST_PARITY: begin
          if (tick) tx_out <= 1'b1;
        end
        ST_STOP: begin
          if (tick && !last_stop) stop_cnt <= 1'b1;
          if (tick) tx_out <= 1'b1;
        end
        default: tx_out <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four instances (8N1, 8E1, 8O1, 7O2) at
// CLKS_PER_BIT=4. Table-driven frames plus hand sequences for
// back-to-back, ignored mid-frame valid and reset mid-frame.
module tb_uart_tx_cfg;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] valid = '0;
  logic [3:0] ready, txo, busy, done;
  logic [8:0] data [4] = '{9'h0, 9'h0, 9'h0, 9'h0};

  int cfg_db  [4] = '{8, 8, 8, 7};
  int cfg_par [4] = '{0, 1, 2, 2};
  int cfg_sb  [4] = '{1, 1, 1, 2};

  int n_total = 0;
  int n_pass  = 0;

  logic exp_q[$];

  typedef struct {
    int         idx;
    logic [8:0] word;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid[0]), .tx_data(data[0][7:0]),
    .tx_ready(ready[0]), .tx_out(txo[0]), .tx_busy(busy[0]), .tx_done(done[0]));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid[1]), .tx_data(data[1][7:0]),
    .tx_ready(ready[1]), .tx_out(txo[1]), .tx_busy(busy[1]), .tx_done(done[1]));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid[2]), .tx_data(data[2][7:0]),
    .tx_ready(ready[2]), .tx_out(txo[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid[3]), .tx_data(data[3][6:0]),
    .tx_ready(ready[3]), .tx_out(txo[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Sends one word and checks the line bit by bit against the expected
  // frame pushed onto exp_q at accept time.
  task automatic run_frame(input int idx, input logic [8:0] word, input logic exp_par,
                           input int exp_len, input bit pre_driven, input bit hold,
                           input logic [8:0] next_word, input int pulse_at);
    int done_at;
    int n_done;
    bit ready_low;
    if (!pre_driven) begin
      @(negedge clk);
      valid[idx] = 1'b1;
      data[idx]  = word;
    end
    chk("ready_before", ready[idx], 1);
    @(posedge clk);
    exp_q.push_back(1'b0);
    for (int i = 0; i < cfg_db[idx]; i++) exp_q.push_back(word[i]);
    if (cfg_par[idx] != 0) exp_q.push_back(exp_par);
    for (int i = 0; i < cfg_sb[idx]; i++) exp_q.push_back(1'b1);
    done_at   = 0;
    n_done    = 0;
    ready_low = 1'b1;
    for (int k = 1; k <= exp_len; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) valid[idx] = 1'b0;
      if (pulse_at > 0 && k == pulse_at) begin
        valid[idx] = 1'b1;
        data[idx]  = 9'h012;
      end
      if (pulse_at > 0 && k == pulse_at + 1) valid[idx] = 1'b0;
      if (hold && k == exp_len) data[idx] = next_word;
      if (ready[idx]) ready_low = 1'b0;
      if (done[idx]) begin
        n_done++;
        if (done_at == 0) done_at = k;
      end
      if (k == 1) chk("start_edge", txo[idx], 0);
      if (k % CPB == 2) chk("line_bit", txo[idx], exp_q.pop_front());
    end
    chk("done_at", done_at, exp_len);
    chk("done_pulses", n_done, 1);
    chk("ready_low", ready_low, 1);
    chk("queue_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("idle_line", txo[idx], 1);
    chk("idle_ready", ready[idx], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    bit stayed_idle;

    vecs[0] = '{0, 9'h055, 1'b0, 40};
    vecs[1] = '{1, 9'h0A5, 1'b0, 44};
    vecs[2] = '{2, 9'h0A5, 1'b1, 44};
    vecs[3] = '{3, 9'h07F, 1'b0, 44};
    vecs[4] = '{0, 9'h000, 1'b0, 40};
    vecs[5] = '{1, 9'h0FF, 1'b0, 44};
    vecs[6] = '{2, 9'h001, 1'b0, 44};
    vecs[7] = '{3, 9'h003, 1'b1, 44};
    vecs[8] = '{1, 9'h001, 1'b1, 44};
    vecs[9] = '{2, 9'h000, 1'b1, 44};

    #12;
    chk("reset_line", txo, 4'hF);
    chk("reset_ready", ready, 4'hF);
    chk("reset_busy", busy, 4'h0);
    chk("reset_done", done, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      run_frame(vecs[v].idx, vecs[v].word, vecs[v].exp_par, vecs[v].exp_len, 1'b0, 1'b0, 9'h0, 0);
    end

    // Back-to-back with tx_valid held: one idle clock, then the next start bit.
    run_frame(0, 9'h000, 1'b0, 40, 1'b0, 1'b1, 9'h0FF, 0);
    run_frame(0, 9'h0FF, 1'b0, 40, 1'b1, 1'b0, 9'h0, 0);

    // A word offered mid-frame must be dropped, not queued.
    run_frame(0, 9'h055, 1'b0, 40, 1'b0, 1'b0, 9'h0, 10);
    stayed_idle = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (busy[0] || !txo[0]) stayed_idle = 1'b0;
    end
    chk("ignored_word", stayed_idle, 1);

    // Reset during data bit 3 (clocks 17..20 after accept).
    @(negedge clk);
    valid[0] = 1'b1;
    data[0]  = 9'h000;
    @(posedge clk);
    saw_done = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) valid[0] = 1'b0;
      if (done[0]) saw_done = 1'b1;
    end
    chk("pre_reset_line", txo[0], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_line", txo[0], 1);
    chk("async_busy", busy[0], 0);
    chk("no_done", saw_done | done[0], 0);
    repeat (2) @(negedge clk);
    chk("reset_hold_done", done[0], 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", ready[0], 1);
    run_frame(0, 9'h055, 1'b0, 40, 1'b0, 1'b0, 9'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
